// File: rtl/alarm_pkg.sv
// Shared types and defaults for the home alarm block.
//   state_t      : alarm FSM state encoding
//   DEF_*        : default passcodes and exit delay used as module parameter defaults
//   to_code()    : raw keypad value -> 5-bit passcode (out-of-range values become NO_KEY)
package alarm_pkg;

  localparam int CODE_W = 5;

  localparam logic [CODE_W-1:0] DEF_ARM_CODE    = 5'd4;
  localparam logic [CODE_W-1:0] DEF_DISARM_CODE = 5'd19;
  localparam logic [CODE_W-1:0] DEF_NO_KEY      = 5'd31;
  localparam int                DEF_EXIT_DELAY  = 2;

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMING   = 2'd1,
    ARMED    = 2'd2,
    ALARM    = 2'd3
  } state_t;

  function automatic logic [CODE_W-1:0] to_code(input logic [7:0] key,
                                                input logic [CODE_W-1:0] no_key);
    return (key <= 8'd30) ? key[CODE_W-1:0] : no_key;
  endfunction

endpackage

// File: rtl/home_alarm_system_if.sv
// Keypad / sensor / indicator bundle for the home alarm block.
//   key_value : raw keypad value
//   motion1/2 : motion sensors, active high
//   reed      : door reed switch, 1 = open
//   code      : registered passcode
//   active    : system armed (ARMING, ARMED or ALARM)
//   alarm     : alarm latched
// slave = the alarm block, master = whatever drives keypad and sensors.
interface home_alarm_system_if;
  import alarm_pkg::*;

  logic [7:0]        key_value;
  logic              motion1;
  logic              motion2;
  logic              reed;
  logic [CODE_W-1:0] code;
  logic              active;
  logic              alarm;

  modport slave (
    input  key_value, motion1, motion2, reed,
    output code, active, alarm
  );

  modport master (
    output key_value, motion1, motion2, reed,
    input  code, active, alarm
  );

endinterface

// File: rtl/passcode_converter.sv
// Registers the keypad value as a 5-bit passcode; values above 30 read as NO_KEY.
//   clk, rst_n : clock, async active-low reset (code resets to NO_KEY)
//   key_value  : raw keypad value
//   code       : converted passcode, one cycle latency
module passcode_converter
  import alarm_pkg::*;
#(
  parameter logic [CODE_W-1:0] NO_KEY = DEF_NO_KEY
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        key_value,
  output logic [CODE_W-1:0] code
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) code <= NO_KEY;
    else        code <= to_code(key_value, NO_KEY);
  end

endmodule

// File: rtl/home_alarm_system.sv
// Keypad-armed intrusion alarm: passcode conversion, edge-style command
// detect, exit-delay down-counter and arm/alarm FSM.
//   clk, rst_n : clock, async active-low reset
//   bus        : keypad, sensors and indicators (slave side)
//
// state    | meaning
// ---------+------------------------------------------------------------
// DISARMED | idle, sensors ignored, waiting for ARM code
// ARMING   | exit delay running, sensors ignored
// ARMED    | any sensor trips the alarm
// ALARM    | alarm latched until DISARM code or reset
module home_alarm_system
  import alarm_pkg::*;
#(
  parameter logic [CODE_W-1:0] ARM_CODE    = DEF_ARM_CODE,
  parameter logic [CODE_W-1:0] DISARM_CODE = DEF_DISARM_CODE,
  parameter logic [CODE_W-1:0] NO_KEY      = DEF_NO_KEY,
  parameter int                EXIT_DELAY  = DEF_EXIT_DELAY
) (
  input logic               clk,
  input logic               rst_n,
  home_alarm_system_if.slave bus
);

  // Counter loads EXIT_DELAY-1 and leaves ARMING on the cycle it reads zero,
  // so ARMING lasts exactly EXIT_DELAY cycles.
  localparam int CNT_W = (EXIT_DELAY > 2) ? $clog2(EXIT_DELAY) : 1;
  localparam logic [CNT_W-1:0] DLY_LOAD = (EXIT_DELAY > 0) ? CNT_W'(EXIT_DELAY - 1) : '0;

  logic [CODE_W-1:0] code;
  logic [CODE_W-1:0] code_q;
  logic              new_code;
  logic              arm_cmd;
  logic              disarm_cmd;
  logic              trip;
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              active_q, alarm_q;

  passcode_converter #(.NO_KEY(NO_KEY)) u_conv (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_value (bus.key_value),
    .code      (code)
  );

  // A held code acts once: it only counts as a command while it differs
  // from the previous cycle's code.
  assign new_code   = (code != code_q) && (code != NO_KEY);
  assign arm_cmd    = new_code && (code == ARM_CODE);
  assign disarm_cmd = new_code && (code == DISARM_CODE);
  assign trip       = bus.motion1 | bus.motion2 | bus.reed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q   <= NO_KEY;
      state_q  <= DISARMED;
      cnt_q    <= '0;
      active_q <= 1'b0;
      alarm_q  <= 1'b0;
    end else begin
      code_q   <= code;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      active_q <= (state_d != DISARMED);
      alarm_q  <= (state_d == ALARM);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (disarm_cmd) begin
      // Disarm wins over a trip on the same edge.
      state_d = DISARMED;
      cnt_d   = '0;
    end else begin
      case (state_q)
        DISARMED: begin
          if (arm_cmd) begin
            if (EXIT_DELAY == 0) begin
              state_d = ARMED;
            end else begin
              state_d = ARMING;
              cnt_d   = DLY_LOAD;
            end
          end
        end
        ARMING: begin
          if (cnt_q == '0) state_d = ARMED;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        ARMED: begin
          if (trip) state_d = ALARM;
        end
        ALARM: begin
          state_d = ALARM;
        end
        default: begin
          state_d = DISARMED;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign bus.code   = code;
  assign bus.active = active_q;
  assign bus.alarm  = alarm_q;

endmodule

// File: tb/tb_home_alarm_system.sv
// Directed, table-driven bench for home_alarm_system.
module tb_home_alarm_system;
  import alarm_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  home_alarm_system_if bus ();

  home_alarm_system dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] key;
    logic [2:0] sens;   // {motion1, motion2, reed}
    logic [4:0] code;
    logic       act;
    logic       alm;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input int idx, input logic [4:0] act_v,
                     input logic [4:0] exp_v);
    n_cmp++;
    if (act_v !== exp_v) begin
      n_bad++;
      $display("FAIL %s [%0d]: got %0d expected %0d", name, idx, act_v, exp_v);
    end
  endtask

  task automatic chk_all(input string tag, input int idx, input logic [4:0] c,
                         input logic a, input logic l);
    chk({tag, ".code"},   idx, bus.code, c);
    chk({tag, ".active"}, idx, {4'd0, bus.active}, {4'd0, a});
    chk({tag, ".alarm"},  idx, {4'd0, bus.alarm},  {4'd0, l});
  endtask

  task automatic drive(input logic [7:0] k, input logic [2:0] s);
    bus.key_value = k;
    {bus.motion1, bus.motion2, bus.reed} = s;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(8'd31, 3'b000);

    // Held in reset: sensors cycle, outputs stay at reset values.
    for (int i = 0; i < 8; i++) begin
      drive(8'd31, 3'(i));
      tick();
      chk_all("reset", i, 5'd31, 1'b0, 1'b0);
    end
    drive(8'd31, 3'b000);
    rst_n = 1'b1;

    //               key     sens    code   act   alm
    tbl.push_back('{8'd4,  3'b000, 5'd4,  1'b0, 1'b0}); // code after 1 clk
    tbl.push_back('{8'd4,  3'b000, 5'd4,  1'b1, 1'b0}); // ARMING
    tbl.push_back('{8'd4,  3'b001, 5'd4,  1'b1, 1'b0}); // reed ignored in delay
    tbl.push_back('{8'd4,  3'b001, 5'd4,  1'b1, 1'b0}); // -> ARMED
    tbl.push_back('{8'd4,  3'b001, 5'd4,  1'b1, 1'b1}); // trip -> ALARM
    tbl.push_back('{8'd4,  3'b000, 5'd4,  1'b1, 1'b1}); // latched
    tbl.push_back('{8'd19, 3'b000, 5'd19, 1'b1, 1'b1});
    tbl.push_back('{8'd19, 3'b000, 5'd19, 1'b0, 1'b0}); // disarmed
    tbl.push_back('{8'd30, 3'b000, 5'd30, 1'b0, 1'b0}); // boundary 30 passes
    tbl.push_back('{8'd31, 3'b000, 5'd31, 1'b0, 1'b0});
    tbl.push_back('{8'd4,  3'b000, 5'd4,  1'b0, 1'b0});
    tbl.push_back('{8'd4,  3'b000, 5'd4,  1'b1, 1'b0});
    tbl.push_back('{8'd4,  3'b000, 5'd4,  1'b1, 1'b0});
    tbl.push_back('{8'd4,  3'b000, 5'd4,  1'b1, 1'b0}); // ARMED
    tbl.push_back('{8'd7,  3'b000, 5'd7,  1'b1, 1'b0});
    tbl.push_back('{8'd7,  3'b000, 5'd7,  1'b1, 1'b0}); // 7 ignored
    tbl.push_back('{8'd44, 3'b000, 5'd31, 1'b1, 1'b0}); // 44 -> NO_KEY
    tbl.push_back('{8'd44, 3'b000, 5'd31, 1'b1, 1'b0});
    tbl.push_back('{8'd19, 3'b000, 5'd19, 1'b1, 1'b0});
    tbl.push_back('{8'd19, 3'b111, 5'd19, 1'b0, 1'b0}); // disarm beats trip
    tbl.push_back('{8'd19, 3'b111, 5'd19, 1'b0, 1'b0});
    tbl.push_back('{8'd31, 3'b000, 5'd31, 1'b0, 1'b0});
    tbl.push_back('{8'd4,  3'b000, 5'd4,  1'b0, 1'b0});
    tbl.push_back('{8'd4,  3'b000, 5'd4,  1'b1, 1'b0}); // ARMING
    tbl.push_back('{8'd4,  3'b010, 5'd4,  1'b1, 1'b0}); // motion2 ignored
    tbl.push_back('{8'd4,  3'b000, 5'd4,  1'b1, 1'b0}); // ARMED
    tbl.push_back('{8'd4,  3'b100, 5'd4,  1'b1, 1'b1}); // motion1 -> ALARM
    tbl.push_back('{8'd31, 3'b000, 5'd31, 1'b1, 1'b1});
    tbl.push_back('{8'd4,  3'b000, 5'd4,  1'b1, 1'b1});
    tbl.push_back('{8'd4,  3'b000, 5'd4,  1'b1, 1'b1}); // ARM in ALARM ignored

    foreach (tbl[i]) begin
      drive(tbl[i].key, tbl[i].sens);
      tick();
      chk_all("vec", i, tbl[i].code, tbl[i].act, tbl[i].alm);
    end

    // Asynchronous reset from ALARM, away from any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 0, 5'd31, 1'b0, 1'b0);
    tick();
    chk_all("async_rst", 1, 5'd31, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Key 4 still held: becomes a fresh ARM command after reset.
    tick();
    chk_all("post_rst", 0, 5'd4, 1'b0, 1'b0);
    tick();
    chk_all("post_rst", 1, 5'd4, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
